alu_scheduler: RTL and testbench

//  Shares one alu instance between two requesters (req0: core issue stage, req1: branch/debug unit).

---
 rtl/alu_scheduler_pkg.sv | 19 +
 rtl/alu_scheduler_if.sv | 44 ++++
 rtl/alu_scheduler_rr_arbiter2.sv | 24 ++
 rtl/alu_scheduler.sv | 128 ++++++++++++
 tb/tb_alu_scheduler.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_scheduler_pkg.sv
// rtl/alu_scheduler_pkg.sv - shared constants, state encoding and op decode for alu_scheduler
package alu_scheduler_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [5:0] ALU_COMPARER  = 6'h01;
  localparam logic [5:0] ALU_JUMP_COND = 6'h02;

  typedef enum logic [1:0] {
    ALU_SCHED_IDLE = 2'd0,
    ALU_SCHED_EXEC = 2'd1,
    ALU_SCHED_RESP = 2'd2
  } sched_state_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == ALU_COMPARER) || (op == ALU_JUMP_COND);
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// rtl/alu_scheduler_if.sv - requester request/response channels plus the shared alu drive/return bus
interface alu_scheduler_if #(
  parameter int DW = 32
);
  logic [1:0]    i_req_valid;
  logic [1:0]    o_req_ready;
  logic [5:0]    i_req0_op;
  logic [DW-1:0] i_req0_operand0;
  logic [DW-1:0] i_req0_operand1;
  logic [DW-1:0] i_req0_direct_addr;
  logic [DW-1:0] i_req0_program_addr;
  logic [5:0]    i_req1_op;
  logic [DW-1:0] i_req1_operand0;
  logic [DW-1:0] i_req1_operand1;
  logic [DW-1:0] i_req1_direct_addr;
  logic [DW-1:0] i_req1_program_addr;
  logic [1:0]    o_rsp_valid;
  logic [1:0]    i_rsp_ready;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_err;
  logic [5:0]    o_unit_alu_output_en;
  logic [DW-1:0] o_operand0;
  logic [DW-1:0] o_operand1;
  logic [DW-1:0] o_direct_addr;
  logic [DW-1:0] o_program_addr;
  logic [DW-1:0] i_alu_output;

  modport slave (
    input  i_req_valid, i_req0_op, i_req0_operand0, i_req0_operand1, i_req0_direct_addr,
           i_req0_program_addr, i_req1_op, i_req1_operand0, i_req1_operand1,
           i_req1_direct_addr, i_req1_program_addr, i_rsp_ready, i_alu_output,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_unit_alu_output_en,
           o_operand0, o_operand1, o_direct_addr, o_program_addr
  );

  modport master (
    output i_req_valid, i_req0_op, i_req0_operand0, i_req0_operand1, i_req0_direct_addr,
           i_req0_program_addr, i_req1_op, i_req1_operand0, i_req1_operand1,
           i_req1_direct_addr, i_req1_program_addr, i_rsp_ready, i_alu_output,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_unit_alu_output_en,
           o_operand0, o_operand1, o_direct_addr, o_program_addr
  );

endinterface

// File: rtl/alu_scheduler_rr_arbiter2.sv
// rtl/alu_scheduler_rr_arbiter2.sv - two-way round-robin arbiter, combinational grant, registered last grant
module alu_scheduler_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_update,
  output logic       o_grant,
  output logic       o_any
);
  logic r_last_grant;

  // Last grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last_grant <= 1'b1;
    else if (i_update) r_last_grant <= o_grant;
  end

  always_comb begin
    o_any = |i_valid;
    if (&i_valid) o_grant = ~r_last_grant;
    else          o_grant = i_valid[1];
  end

endmodule

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - shares one alu between two requesters, one operation in flight at a time
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int DW      = DATA_WIDTH,
  parameter int ALU_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  alu_scheduler_if.slave bus
);
  if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
    $error("alu_scheduler: ALU_LAT must be in 1..15");
  end

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  sched_state_t  r_state;
  sched_state_t  w_next;
  logic          w_grant;
  logic          w_any;
  logic          w_accept;
  logic          w_rsp_hs;
  logic [1:0]    w_req_ready;
  logic [1:0]    w_rsp_valid;
  logic [5:0]    w_op;
  logic [DW-1:0] w_operand0;
  logic [DW-1:0] w_operand1;
  logic [DW-1:0] w_direct_addr;
  logic [DW-1:0] w_program_addr;

  logic          r_grant;
  logic [3:0]    r_cnt;
  logic [5:0]    r_en;
  logic [DW-1:0] r_operand0;
  logic [DW-1:0] r_operand1;
  logic [DW-1:0] r_direct_addr;
  logic [DW-1:0] r_program_addr;
  logic [DW-1:0] r_data;
  logic          r_err;

  alu_scheduler_rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (bus.i_req_valid),
    .i_update (w_accept),
    .o_grant  (w_grant),
    .o_any    (w_any)
  );

  // Ready is gated by rst so no accept is advertised while reset is held.
  assign w_accept       = (r_state == ALU_SCHED_IDLE) && w_any && !rst;
  assign w_rsp_hs       = (r_state == ALU_SCHED_RESP) && bus.i_rsp_ready[r_grant];
  assign w_op           = w_grant ? bus.i_req1_op           : bus.i_req0_op;
  assign w_operand0     = w_grant ? bus.i_req1_operand0     : bus.i_req0_operand0;
  assign w_operand1     = w_grant ? bus.i_req1_operand1     : bus.i_req0_operand1;
  assign w_direct_addr  = w_grant ? bus.i_req1_direct_addr  : bus.i_req0_direct_addr;
  assign w_program_addr = w_grant ? bus.i_req1_program_addr : bus.i_req0_program_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ALU_SCHED_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ALU_SCHED_IDLE: if (w_accept) w_next = op_supported(w_op) ? ALU_SCHED_EXEC : ALU_SCHED_RESP;
      ALU_SCHED_EXEC: if (r_cnt == 4'd0) w_next = ALU_SCHED_RESP;
      ALU_SCHED_RESP: if (w_rsp_hs) w_next = ALU_SCHED_IDLE;
      default:        w_next = ALU_SCHED_IDLE;
    endcase
  end

  always_comb begin
    w_req_ready = 2'b00;
    w_rsp_valid = 2'b00;
    if (w_accept)                      w_req_ready[w_grant] = 1'b1;
    if (r_state == ALU_SCHED_RESP)     w_rsp_valid[r_grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant        <= 1'b0;
      r_cnt          <= 4'd0;
      r_en           <= 6'h0;
      r_operand0     <= '0;
      r_operand1     <= '0;
      r_direct_addr  <= '0;
      r_program_addr <= '0;
      r_data         <= '0;
      r_err          <= 1'b0;
    end else begin
      if (w_accept) begin
        r_grant        <= w_grant;
        r_cnt          <= LAT_M1;
        r_operand0     <= w_operand0;
        r_operand1     <= w_operand1;
        r_direct_addr  <= w_direct_addr;
        r_program_addr <= w_program_addr;
        if (op_supported(w_op)) begin
          r_en  <= w_op;
          r_err <= 1'b0;
        end else begin
          r_en   <= 6'h0;
          r_data <= '0;
          r_err  <= 1'b1;
        end
      end
      if (r_state == ALU_SCHED_EXEC) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd0) r_data <= bus.i_alu_output;
      end
      if (w_rsp_hs) r_en <= 6'h0;
    end
  end

  assign bus.o_req_ready          = w_req_ready;
  assign bus.o_rsp_valid          = w_rsp_valid;
  assign bus.o_rsp_data           = r_data;
  assign bus.o_rsp_err            = r_err;
  assign bus.o_unit_alu_output_en = r_en;
  assign bus.o_operand0           = r_operand0;
  assign bus.o_operand1           = r_operand1;
  assign bus.o_direct_addr        = r_direct_addr;
  assign bus.o_program_addr       = r_program_addr;

endmodule

// File: tb/tb_alu_scheduler.sv
// tb/tb_alu_scheduler.sv - directed self-checking bench for alu_scheduler at ALU_LAT 1 and 3
module tb_alu_scheduler;
  import alu_scheduler_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_scheduler_if #(.DW(32)) b1 ();
  alu_scheduler_if #(.DW(32)) b3 ();

  alu_scheduler #(.DW(32), .ALU_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  alu_scheduler #(.DW(32), .ALU_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    b1.i_req_valid = 2'b11; b1.i_rsp_ready = 2'b00; b1.i_alu_output = '0;
    b1.i_req0_op = ALU_COMPARER; b1.i_req0_operand0 = '0; b1.i_req0_operand1 = '0;
    b1.i_req0_direct_addr = '0; b1.i_req0_program_addr = '0;
    b1.i_req1_op = ALU_JUMP_COND; b1.i_req1_operand0 = '0; b1.i_req1_operand1 = '0;
    b1.i_req1_direct_addr = '0; b1.i_req1_program_addr = '0;
    b3.i_req_valid = 2'b00; b3.i_rsp_ready = 2'b00; b3.i_alu_output = '0;
    b3.i_req0_op = '0; b3.i_req0_operand0 = '0; b3.i_req0_operand1 = '0;
    b3.i_req0_direct_addr = '0; b3.i_req0_program_addr = '0;
    b3.i_req1_op = '0; b3.i_req1_operand0 = '0; b3.i_req1_operand1 = '0;
    b3.i_req1_direct_addr = '0; b3.i_req1_program_addr = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(b1.o_req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(b1.o_rsp_valid), 32'h0);
    chk("rst_alu_en",    32'(b1.o_unit_alu_output_en), 32'h0);
    chk("rst_rsp_data",  b1.o_rsp_data, 32'h0);
    chk("rst_rsp_err",   32'(b1.o_rsp_err), 32'h0);
    rst = 1'b0;
    b1.i_req_valid = 2'b00;
    tick();

    // 1: single req0 COMPARER op
    b1.i_req0_op = ALU_COMPARER; b1.i_req0_operand0 = 32'd5; b1.i_req0_operand1 = 32'd7;
    b1.i_req0_direct_addr = 32'h100; b1.i_req0_program_addr = 32'h200;
    b1.i_alu_output = 32'hDEAD0001;
    b1.i_req_valid = 2'b01;
    #1;
    chk("t1_req_ready", 32'(b1.o_req_ready), 32'h1);
    tick();
    b1.i_req_valid = 2'b00;
    #1;
    chk("t1_alu_en",    32'(b1.o_unit_alu_output_en), 32'(ALU_COMPARER));
    chk("t1_operand0",  b1.o_operand0, 32'd5);
    chk("t1_direct",    b1.o_direct_addr, 32'h100);
    chk("t1_program",   b1.o_program_addr, 32'h200);
    chk("t1_rsp_early", 32'(b1.o_rsp_valid), 32'h0);
    tick();
    chk("t1_rsp_valid", 32'(b1.o_rsp_valid), 32'h1);
    chk("t1_rsp_data",  b1.o_rsp_data, 32'hDEAD0001);
    chk("t1_rsp_err",   32'(b1.o_rsp_err), 32'h0);
    b1.i_rsp_ready = 2'b01;
    tick();
    b1.i_rsp_ready = 2'b00;
    chk("t1_rsp_done",  32'(b1.o_rsp_valid), 32'h0);
    chk("t1_en_clear",  32'(b1.o_unit_alu_output_en), 32'h0);

    // 2: both valid, back-to-back, grants alternate (req0 won last)
    b1.i_req1_op = ALU_JUMP_COND;
    b1.i_req_valid = 2'b11;
    b1.i_rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (b1.o_req_ready == 2'b00 && w < 10) begin
        tick();
        w++;
      end
      chk($sformatf("t2_grant%0d", k), 32'(b1.o_req_ready), (k % 2 == 0) ? 32'h2 : 32'h1);
      tick();
    end
    b1.i_req_valid = 2'b00;
    tick();
    tick();
    b1.i_rsp_ready = 2'b00;

    // 3: req1 JUMP_COND with response stalled; req0 waits
    b1.i_req1_op = ALU_JUMP_COND; b1.i_req1_operand0 = 32'd3;
    b1.i_alu_output = 32'hCAFE;
    b1.i_req_valid = 2'b10;
    #1;
    chk("t3_req_ready", 32'(b1.o_req_ready), 32'h2);
    tick();
    b1.i_req_valid = 2'b01;
    b1.i_rsp_ready = 2'b01;
    #1;
    chk("t3_exec_noacc", 32'(b1.o_req_ready), 32'h0);
    tick();
    b1.i_alu_output = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_valid%0d", i), 32'(b1.o_rsp_valid), 32'h2);
      chk($sformatf("t3_data%0d", i),  b1.o_rsp_data, 32'hCAFE);
      chk($sformatf("t3_noacc%0d", i), 32'(b1.o_req_ready), 32'h0);
      tick();
    end
    b1.i_rsp_ready = 2'b10;
    #1;
    chk("t3_hs_noacc", 32'(b1.o_req_ready), 32'h0);
    tick();
    chk("t3_accept0",  32'(b1.o_req_ready), 32'h1);
    chk("t3_rsp_done", 32'(b1.o_rsp_valid), 32'h0);
    b1.i_alu_output = 32'h7777;
    tick();
    b1.i_req_valid = 2'b00;
    b1.i_rsp_ready = 2'b01;
    tick();
    chk("t3_req0_data", b1.o_rsp_data, 32'h7777);
    tick();
    b1.i_rsp_ready = 2'b00;

    // 4: unsupported op
    b1.i_req0_op = 6'h3F;
    b1.i_req_valid = 2'b01;
    #1;
    chk("t4_req_ready", 32'(b1.o_req_ready), 32'h1);
    tick();
    b1.i_req_valid = 2'b00;
    #1;
    chk("t4_rsp_valid", 32'(b1.o_rsp_valid), 32'h1);
    chk("t4_rsp_err",   32'(b1.o_rsp_err), 32'h1);
    chk("t4_rsp_data",  b1.o_rsp_data, 32'h0);
    chk("t4_alu_en",    32'(b1.o_unit_alu_output_en), 32'h0);
    b1.i_rsp_ready = 2'b01;
    tick();
    b1.i_rsp_ready = 2'b00;
    chk("t4_rsp_done",  32'(b1.o_rsp_valid), 32'h0);
    chk("t4_alu_en2",   32'(b1.o_unit_alu_output_en), 32'h0);

    // 5: ALU_LAT=3 capture timing
    b3.i_req0_op = ALU_COMPARER; b3.i_req0_operand0 = 32'd9; b3.i_req0_operand1 = 32'd3;
    b3.i_req0_program_addr = 32'h44;
    b3.i_req_valid = 2'b01;
    #1;
    chk("t5_req_ready", 32'(b3.o_req_ready), 32'h1);
    tick();
    b3.i_req_valid = 2'b00;
    b3.i_alu_output = 32'hA1;
    #1;
    chk("t5_alu_en",   32'(b3.o_unit_alu_output_en), 32'(ALU_COMPARER));
    chk("t5_op0_c1",   b3.o_operand0, 32'd9);
    chk("t5_rsp_c1",   32'(b3.o_rsp_valid), 32'h0);
    tick();
    b3.i_alu_output = 32'hA2;
    #1;
    chk("t5_op0_c2",   b3.o_operand0, 32'd9);
    chk("t5_op1_c2",   b3.o_operand1, 32'd3);
    chk("t5_rsp_c2",   32'(b3.o_rsp_valid), 32'h0);
    tick();
    b3.i_alu_output = 32'hA3;
    #1;
    chk("t5_prog_c3",  b3.o_program_addr, 32'h44);
    chk("t5_rsp_c3",   32'(b3.o_rsp_valid), 32'h0);
    tick();
    b3.i_alu_output = 32'h0;
    chk("t5_rsp_valid", 32'(b3.o_rsp_valid), 32'h1);
    chk("t5_rsp_data",  b3.o_rsp_data, 32'hA3);
    b3.i_rsp_ready = 2'b01;
    tick();
    b3.i_rsp_ready = 2'b00;
    chk("t5_rsp_done",  32'(b3.o_rsp_valid), 32'h0);

    // 6: reset during EXEC; last grant was req0, so without reset req1 would win next
    b1.i_req0_op = ALU_COMPARER; b1.i_req0_operand0 = 32'h66;
    b1.i_req_valid = 2'b01;
    tick();
    b1.i_req_valid = 2'b11;
    #1;
    chk("t6_exec_en", 32'(b1.o_unit_alu_output_en), 32'(ALU_COMPARER));
    rst = 1'b1;
    #1;
    chk("t6_rst_en",        32'(b1.o_unit_alu_output_en), 32'h0);
    chk("t6_rst_operand0",  b1.o_operand0, 32'h0);
    chk("t6_rst_rsp_valid", 32'(b1.o_rsp_valid), 32'h0);
    chk("t6_rst_req_ready", 32'(b1.o_req_ready), 32'h0);
    chk("t6_rst_rsp_data",  b1.o_rsp_data, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_next_grant", 32'(b1.o_req_ready), 32'h1);
    chk("t6_no_rsp",     32'(b1.o_rsp_valid), 32'h0);
    b1.i_req_valid = 2'b00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
